// File: rtl/sccb_target.sv
// sccb_target
//   SCCB / I2C responder. SCL and SDA are oversampled with the fast system
//   clock; START/STOP, the device address, the register pointer and write/read
//   data bytes are decoded. SDA is driven open-drain through sda_oe_o.
//   Register accesses are presented as one-cycle strobes.
//
// Parameters
//   DEVICE_ADDR  7-bit target address (write 0x42 / read 0x43 for 7'h21)
//   SYNC_STAGES  flops in each SCL/SDA input synchroniser (>= 2)
//
// Ports
//   clk_i        system clock, at least 20x the SCL frequency
//   reset_ni     asynchronous active-low reset
//   scl_i        bus SCL (never stretched by this target)
//   sda_i        bus SDA as seen at the pad
//   sda_oe_o     1 = pull SDA low, 0 = release
//   reg_addr_o   register pointer, valid with reg_we_o / reg_re_o
//   reg_wdata_o  write data, valid with reg_we_o
//   reg_we_o     one-cycle write strobe
//   reg_re_o     one-cycle read strobe
//   reg_rdata_i  read data, sampled one clock after reg_re_o
//   busy_o       high from an addressed START until the following STOP
module sccb_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_dly, sda_dly;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_det, stop_det;
    logic [2:0]             bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             byte_in;
    logic                   byte_done;
    logic                   addr_match;
    logic                   rw_q;
    logic                   load_p1;

    // Input synchronisers plus one extra flop for edge detection. They reset
    // to the idle-bus level so leaving reset never fakes a START.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_dly  <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_dly  <= scl_sync[SYNC_STAGES-1];
            sda_dly  <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_dly;
    assign scl_fall = ~scl_s & scl_dly;
    assign sda_rise = sda_s & ~sda_dly;
    assign sda_fall = ~sda_s & sda_dly;

    // SCL must be high on both samples so an SDA change that lands next to
    // an SCL edge is not mistaken for a bus condition.
    assign start_det = sda_fall & scl_s & scl_dly;
    assign stop_det  = sda_rise & scl_s & scl_dly;

    assign byte_in    = {shift[6:0], sda_s};
    assign byte_done  = scl_rise & (bit_cnt == 3'd7);
    // On the 8th rise shift[6:0] holds the seven address bits; sda_s is R/W.
    assign addr_match = (shift[6:0] == DEVICE_ADDR);

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In the ACK states sda_oe_o doubles as the phase flag:
    // low until the 8th SCL fall, high until the 9th.
    always_comb begin
        state_next = state;
        if (start_det) begin
            state_next = ADDR;
        end else if (stop_det) begin
            state_next = IDLE;
        end else begin
            case (state)
                ADDR:      if (byte_done) state_next = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:  if (scl_fall && sda_oe_o) state_next = rw_q ? RDATA : REG;
                REG:       if (byte_done) state_next = REG_ACK;
                REG_ACK:   if (scl_fall && sda_oe_o) state_next = WDATA;
                WDATA:     if (byte_done) state_next = WDATA_ACK;
                WDATA_ACK: if (scl_fall && sda_oe_o) state_next = WDATA;
                RDATA:     if (!load_p1 && scl_fall && bit_cnt == 3'd7) state_next = RDATA_ACK;
                RDATA_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_next = IGNORE;
                    end else if (scl_fall) begin
                        state_next = RDATA;
                    end
                end
                default:   state_next = state;
            endcase
        end
    end

    // Output logic: the read strobe coincides with the SCL fall that closes
    // the address ACK (read direction) or a controller ACK after read data.
    always_comb begin
        reg_re_o = 1'b0;
        if (!start_det && !stop_det && scl_fall) begin
            if (state == ADDR_ACK && sda_oe_o && rw_q) begin
                reg_re_o = 1'b1;
            end
            if (state == RDATA_ACK) begin
                reg_re_o = 1'b1;
            end
        end
    end

    // Control and register-bus datapath
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sda_oe_o    <= 1'b0;
            busy_o      <= 1'b0;
            reg_addr_o  <= 8'h00;
            reg_wdata_o <= 8'h00;
            reg_we_o    <= 1'b0;
            bit_cnt     <= 3'd0;
            rw_q        <= 1'b0;
            load_p1     <= 1'b0;
        end else begin
            reg_we_o <= 1'b0;
            load_p1  <= reg_re_o;
            if (start_det) begin
                sda_oe_o <= 1'b0;
                bit_cnt  <= 3'd0;
            end else if (stop_det) begin
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
                bit_cnt  <= 3'd0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rw_q <= sda_s;
                                if (addr_match) busy_o <= 1'b1;
                            end
                        end
                    end
                    REG: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) reg_addr_o <= byte_in;
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                reg_we_o    <= 1'b1;
                                reg_wdata_o <= byte_in;
                            end
                        end
                    end
                    ADDR_ACK, REG_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= ~sda_oe_o;
                            bit_cnt  <= 3'd0;
                        end
                    end
                    WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= ~sda_oe_o;
                            bit_cnt  <= 3'd0;
                            if (sda_oe_o) reg_addr_o <= reg_addr_o + 8'd1;
                        end
                    end
                    RDATA: begin
                        // The MSB goes out as soon as read data arrives; the
                        // remaining seven bits follow on SCL falls, and the
                        // 8th fall hands SDA back for the controller's ACK.
                        if (load_p1) begin
                            sda_oe_o <= ~reg_rdata_i[7];
                            bit_cnt  <= 3'd0;
                        end else if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                sda_oe_o <= 1'b0;
                            end else begin
                                sda_oe_o <= ~shift[7];
                                bit_cnt  <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        // Advance on the ACK so the following read strobe
                        // already carries the next address.
                        if (scl_rise && !sda_s) reg_addr_o <= reg_addr_o + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte shift register (data only, no reset): assembles incoming bytes
    // and serialises outgoing read data.
    always_ff @(posedge clk_i) begin
        if (load_p1) begin
            shift <= {reg_rdata_i[6:0], 1'b0};
        end else if (scl_rise && (state == ADDR || state == REG || state == WDATA)) begin
            shift <= byte_in;
        end else if (scl_fall && state == RDATA) begin
            shift <= {shift[6:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target
//   Self-checking bench for sccb_target: a bit-banged bus controller drives
//   SCL/SDA (open-drain wired-AND with the target), a monitor logs register
//   strobes, and directed write/read/abort/reset sequences are compared
//   against hand-computed expectations.
module tb_sccb_target;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       scl;
    logic       sda_ctrl;
    logic       sda_bus;
    logic       sda_oe_o;
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_we_o;
    logic       reg_re_o;
    logic [7:0] reg_rdata_i;
    logic       busy_o;

    always #5 clk_i = ~clk_i;

    assign sda_bus = sda_ctrl & ~sda_oe_o;

    always_comb begin
        case (reg_addr_o)
            8'h0A:   reg_rdata_i = 8'h5C;
            8'h0B:   reg_rdata_i = 8'h3D;
            default: reg_rdata_i = 8'hEE;
        endcase
    end

    sccb_target #(.DEVICE_ADDR(7'h21), .SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .scl_i       (scl),
        .sda_i       (sda_bus),
        .sda_oe_o    (sda_oe_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_rdata_i (reg_rdata_i),
        .busy_o      (busy_o)
    );

    // Strobe monitor, sampled on the falling edge
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         oe_cycles = 0;
    int         busy_cycles = 0;
    logic [7:0] we_addr [0:63];
    logic [7:0] we_data [0:63];
    logic [7:0] re_addr [0:63];

    always @(negedge clk_i) begin
        if (reg_we_o) begin
            we_addr[we_cnt % 64] = reg_addr_o;
            we_data[we_cnt % 64] = reg_wdata_o;
            we_cnt++;
        end
        if (reg_re_o) begin
            re_addr[re_cnt % 64] = reg_addr_o;
            re_cnt++;
        end
        if (sda_oe_o) oe_cycles++;
        if (busy_o) busy_cycles++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Every bus cell starts by pulling SCL low and ends with SCL high.
    task automatic bus_start();
        scl = 1'b0;      wait_clk(10);
        sda_ctrl = 1'b1; wait_clk(10);
        scl = 1'b1;      wait_clk(20);
        sda_ctrl = 1'b0; wait_clk(20);
    endtask

    task automatic bus_stop();
        scl = 1'b0;      wait_clk(10);
        sda_ctrl = 1'b0; wait_clk(10);
        scl = 1'b1;      wait_clk(20);
        sda_ctrl = 1'b1; wait_clk(20);
    endtask

    task automatic send_bit(input logic b);
        scl = 1'b0; wait_clk(10);
        sda_ctrl = b; wait_clk(10);
        scl = 1'b1; wait_clk(20);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        scl = 1'b0;      wait_clk(10);
        sda_ctrl = 1'b1; wait_clk(10);
        scl = 1'b1;      wait_clk(10);
        ack = ~sda_bus;  wait_clk(10);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            scl = 1'b0;      wait_clk(10);
            sda_ctrl = 1'b1; wait_clk(10);
            scl = 1'b1;      wait_clk(10);
            v[i] = sda_bus;  wait_clk(10);
        end
        scl = 1'b0;      wait_clk(10);
        sda_ctrl = ~ack; wait_clk(10);
        scl = 1'b1;      wait_clk(20);
        b = v;
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_we;
    } wr_vec_t;

    initial begin
        wr_vec_t    vecs [4];
        logic [7:0] exp_ptr;
        logic       a0, a1, a2, a3, a4;
        logic [7:0] r0, r1;
        logic [7:0] adr;
        int         we0, re0, oe0, b0;

        vecs[0] = '{dev: 8'h42, ptr: 8'h12, data: 8'h80, exp_ack: 1'b1, exp_we: 1};
        vecs[1] = '{dev: 8'h44, ptr: 8'h33, data: 8'h55, exp_ack: 1'b0, exp_we: 0};
        vecs[2] = '{dev: 8'h42, ptr: 8'h00, data: 8'hFF, exp_ack: 1'b1, exp_we: 1};
        vecs[3] = '{dev: 8'h42, ptr: 8'h7F, data: 8'h01, exp_ack: 1'b1, exp_we: 1};
        exp_ptr = 8'h00;

        reset_ni = 1'b0;
        scl      = 1'b1;
        sda_ctrl = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", sda_oe_o, 0);
        check("rst_reg_addr", reg_addr_o, 0);
        check("rst_reg_wdata", reg_wdata_o, 0);
        check("rst_we", reg_we_o, 0);
        check("rst_re", reg_re_o, 0);
        check("rst_busy", busy_o, 0);
        reset_ni = 1'b1;
        wait_clk(10);

        // Single-byte writes, addressed and unaddressed
        for (int v = 0; v < 4; v++) begin
            we0 = we_cnt; re0 = re_cnt; oe0 = oe_cycles; b0 = busy_cycles;
            bus_start();
            write_byte(vecs[v].dev, a0);
            write_byte(vecs[v].ptr, a1);
            write_byte(vecs[v].data, a2);
            check($sformatf("v%0d_busy_before_stop", v), busy_o, vecs[v].exp_ack);
            bus_stop();
            wait_clk(5);
            check($sformatf("v%0d_ack_addr", v), a0, vecs[v].exp_ack);
            check($sformatf("v%0d_ack_reg", v), a1, vecs[v].exp_ack);
            check($sformatf("v%0d_ack_data", v), a2, vecs[v].exp_ack);
            check($sformatf("v%0d_we_count", v), we_cnt - we0, vecs[v].exp_we);
            check($sformatf("v%0d_re_count", v), re_cnt - re0, 0);
            check($sformatf("v%0d_oe_seen", v), oe_cycles != oe0, vecs[v].exp_ack);
            check($sformatf("v%0d_busy_seen", v), busy_cycles != b0, vecs[v].exp_ack);
            check($sformatf("v%0d_busy_after_stop", v), busy_o, 0);
            if (vecs[v].exp_we == 1) begin
                check($sformatf("v%0d_we_addr", v), we_addr[we0 % 64], vecs[v].ptr);
                check($sformatf("v%0d_we_data", v), we_data[we0 % 64], vecs[v].data);
            end
            if (vecs[v].exp_ack) exp_ptr = vecs[v].ptr + 8'd1;
            check($sformatf("v%0d_ptr_end", v), reg_addr_o, exp_ptr);
        end

        // Burst write across the pointer wrap
        we0 = we_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'hFE, a1);
        write_byte(8'hA1, a2);
        write_byte(8'hB2, a3);
        write_byte(8'hC3, a4);
        bus_stop();
        wait_clk(5);
        check("wrap_acks", {a0, a1, a2, a3, a4}, 5'b11111);
        check("wrap_we_count", we_cnt - we0, 3);
        check("wrap_addr0", we_addr[(we0 + 0) % 64], 8'hFE);
        check("wrap_data0", we_data[(we0 + 0) % 64], 8'hA1);
        check("wrap_addr1", we_addr[(we0 + 1) % 64], 8'hFF);
        check("wrap_data1", we_data[(we0 + 1) % 64], 8'hB2);
        check("wrap_addr2", we_addr[(we0 + 2) % 64], 8'h00);
        check("wrap_data2", we_data[(we0 + 2) % 64], 8'hC3);
        check("wrap_ptr_end", reg_addr_o, 8'h01);

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        we0 = we_cnt; re0 = re_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h0A, a1);
        bus_start();
        write_byte(8'h43, a2);
        read_byte(1'b1, r0);
        read_byte(1'b0, r1);
        wait_clk(5);
        check("rd_sda_released", sda_oe_o, 0);
        check("rd_busy_before_stop", busy_o, 1);
        bus_stop();
        wait_clk(5);
        check("rd_acks", {a0, a1, a2}, 3'b111);
        check("rd_byte0", r0, 8'h5C);
        check("rd_byte1", r1, 8'h3D);
        check("rd_re_count", re_cnt - re0, 2);
        check("rd_re_addr0", re_addr[(re0 + 0) % 64], 8'h0A);
        check("rd_re_addr1", re_addr[(re0 + 1) % 64], 8'h0B);
        check("rd_we_count", we_cnt - we0, 0);
        check("rd_ptr_end", reg_addr_o, 8'h0B);
        check("rd_busy_after_stop", busy_o, 0);

        // STOP after four bits of a data byte
        we0 = we_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h20, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        wait_clk(5);
        check("abort_acks", {a0, a1}, 2'b11);
        check("abort_we_count", we_cnt - we0, 0);
        check("abort_ptr", reg_addr_o, 8'h20);
        check("abort_busy", busy_o, 0);
        we0 = we_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h30, a1);
        write_byte(8'h77, a2);
        bus_stop();
        wait_clk(5);
        check("after_abort_acks", {a0, a1, a2}, 3'b111);
        check("after_abort_we_count", we_cnt - we0, 1);
        check("after_abort_we_addr", we_addr[we0 % 64], 8'h30);
        check("after_abort_we_data", we_data[we0 % 64], 8'h77);

        // Asynchronous reset in the middle of the address ACK slot
        adr = 8'h42;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(adr[i]);
        scl = 1'b0;
        wait_clk(10);
        check("rstack_oe_before", sda_oe_o, 1);
        #2 reset_ni = 1'b0;
        #1;
        check("rstack_oe_async", sda_oe_o, 0);
        check("rstack_busy_async", busy_o, 0);
        check("rstack_ptr_async", reg_addr_o, 8'h00);
        wait_clk(3);
        sda_ctrl = 1'b1;
        reset_ni = 1'b1;
        wait_clk(5);
        scl = 1'b1;
        wait_clk(20);
        we0 = we_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        check("rstack_busy_before_stop", busy_o, 1);
        bus_stop();
        wait_clk(5);
        check("rstack_acks", {a0, a1, a2}, 3'b111);
        check("rstack_we_count", we_cnt - we0, 1);
        check("rstack_we_addr", we_addr[we0 % 64], 8'h12);
        check("rstack_we_data", we_data[we0 % 64], 8'h80);
        check("rstack_busy_after_stop", busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
